// File: rtl/ship_renderer.sv
// Purpose: turn the ship x position into erase-then-draw pixel writes for the 160x120 VGA adapter.
// Latency: 1 + 2*W*H + 1 cycles per moved redraw, 2 + W*H for the first one, 2 if the ship has not moved.
// Backpressure: none; the VGA adapter takes one pixel per cycle, and a frame_tick that arrives while busy is dropped.
module ship_renderer #(
  parameter int         SHIP_W      = 8,
  parameter int         SHIP_H      = 4,
  parameter logic [6:0] SHIP_Y      = 7'd112,
  parameter logic [2:0] SHIP_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR   = 3'b000,
  parameter int         SCREEN_W    = 160
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] x_val,
  input  logic       frame_tick,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ERASE,
    S_DRAW,
    S_FINISH
  } state_t;

  localparam logic [3:0] COL_LAST   = 4'(SHIP_W - 1);
  localparam logic [2:0] ROW_LAST   = 3'(SHIP_H - 1);
  localparam logic [8:0] SCREEN_LIM = 9'(SCREEN_W);

  state_t     state_q, state_d;
  logic [3:0] col_q, col_d;
  logic [2:0] row_q, row_d;
  logic [7:0] new_x_q, new_x_d;
  logic [7:0] drawn_x_q, drawn_x_d;
  logic       drawn_valid_q, drawn_valid_d;

  // Pixel to present in the next cycle, so that the pixel outputs line up with the state.
  logic       scan_en;
  logic [7:0] scan_base;
  logic [2:0] scan_colour;
  logic [8:0] pix_x9;
  logic [6:0] pix_y;
  logic       plot_d;
  logic       last_pixel;

  assign last_pixel = (col_q == COL_LAST) && (row_q == ROW_LAST);

  // Next-state logic, scan counters, and selection of the next pixel's base and colour.
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    new_x_d       = new_x_q;
    drawn_x_d     = drawn_x_q;
    drawn_valid_d = drawn_valid_q;
    scan_en       = 1'b0;
    scan_base     = new_x_q;
    scan_colour   = SHIP_COLOUR;

    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          state_d = S_CHECK;
          new_x_d = x_val;
        end
      end

      S_CHECK: begin
        col_d = 4'd0;
        row_d = 3'd0;
        if (drawn_valid_q && (new_x_q == drawn_x_q)) begin
          state_d = S_FINISH;
        end else if (drawn_valid_q) begin
          state_d     = S_ERASE;
          scan_en     = 1'b1;
          scan_base   = drawn_x_q;
          scan_colour = BG_COLOUR;
        end else begin
          state_d = S_DRAW;
          scan_en = 1'b1;
        end
      end

      S_ERASE: begin
        scan_en = 1'b1;
        if (last_pixel) begin
          // Draw phase follows directly, with no gap cycle.
          state_d = S_DRAW;
          col_d   = 4'd0;
          row_d   = 3'd0;
        end else begin
          scan_base   = drawn_x_q;
          scan_colour = BG_COLOUR;
          if (col_q == COL_LAST) begin
            col_d = 4'd0;
            row_d = row_q + 3'd1;
          end else begin
            col_d = col_q + 4'd1;
          end
        end
      end

      S_DRAW: begin
        if (last_pixel) begin
          state_d       = S_FINISH;
          drawn_x_d     = new_x_q;
          drawn_valid_d = 1'b1;
        end else begin
          scan_en = 1'b1;
          if (col_q == COL_LAST) begin
            col_d = 4'd0;
            row_d = row_q + 3'd1;
          end else begin
            col_d = col_q + 4'd1;
          end
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The x sum is done in 9 bits so that sprites near the right edge clip instead of wrapping.
    pix_x9 = {1'b0, scan_base} + {5'b0, col_d};
    pix_y  = SHIP_Y + {4'b0, row_d};
    plot_d = scan_en && (pix_x9 < SCREEN_LIM);
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Scan counters, the ship position record, and registered VGA/status outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      col_q         <= 4'd0;
      row_q         <= 3'd0;
      new_x_q       <= 8'd0;
      drawn_x_q     <= 8'd0;
      drawn_valid_q <= 1'b0;
      vga_x         <= 8'd0;
      vga_y         <= 7'd0;
      vga_colour    <= 3'd0;
      vga_plot      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      new_x_q       <= new_x_d;
      drawn_x_q     <= drawn_x_d;
      drawn_valid_q <= drawn_valid_d;
      vga_plot      <= plot_d;
      busy          <= (state_d != S_IDLE);
      done          <= (state_d == S_FINISH);
      // Coordinates and colour hold their last values on cycles with no plot.
      if (plot_d) begin
        vga_x      <= pix_x9[7:0];
        vga_y      <= pix_y;
        vga_colour <= scan_colour;
      end
    end
  end

endmodule

// File: tb/tb_ship_renderer.sv
module tb_ship_renderer;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] x_val;
  logic       frame_tick;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       done;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] cap_x[$];
  logic [6:0] cap_y[$];
  logic [2:0] cap_c[$];
  int         cap_cyc[$];
  logic       cyc_plot [0:159];
  logic [7:0] cyc_x    [0:159];

  always #5 clock = ~clock;

  ship_renderer dut (
    .clock      (clock),
    .reset      (reset),
    .x_val      (x_val),
    .frame_tick (frame_tick),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Accept a tick with x position xv, then record every cycle until 3 cycles past the first done.
  // Cycle 1 is the first cycle after the accepting edge.
  task automatic run_redraw(input logic [7:0] xv, input int tk1, input int tk2,
                            input logic [7:0] mid_x, input int mid_cyc,
                            output int n_plots, output int done_cyc,
                            output int n_done, output int n_busy);
    cap_x.delete();
    cap_y.delete();
    cap_c.delete();
    cap_cyc.delete();
    for (int i = 0; i < 160; i++) begin
      cyc_plot[i] = 1'b0;
      cyc_x[i]    = 8'd0;
    end
    n_plots  = 0;
    done_cyc = -1;
    n_done   = 0;
    n_busy   = 0;
    x_val      = xv;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    for (int cyc = 1; cyc < 150; cyc++) begin
      cyc_plot[cyc] = vga_plot;
      cyc_x[cyc]    = vga_x;
      if (busy) n_busy++;
      if (vga_plot) begin
        n_plots++;
        cap_x.push_back(vga_x);
        cap_y.push_back(vga_y);
        cap_c.push_back(vga_colour);
        cap_cyc.push_back(cyc);
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      frame_tick = (cyc == tk1) || (cyc == tk2);
      if (cyc == mid_cyc) x_val = mid_x;
      step();
    end
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    frame_tick = 1'b0;
    x_val      = 8'd0;
    step();
    step();
    vectors++;
    if ({vga_x, vga_y, vga_colour, vga_plot, busy, done} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0", {vga_x, vga_y, vga_colour, vga_plot, busy, done});
    end
    reset = 1'b1;
    step();
    vectors++;
    if ({busy, done, vga_plot} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_release_idle: got %b expected 000", {busy, done, vga_plot});
    end
  endtask

  task automatic test_first_draw();
    int np, dc, nd, nb;
    logic [17:0] got, exp;
    run_redraw(8'd0, 0, 0, 8'd0, 0, np, dc, nd, nb);
    vectors++;
    if (np !== 32) begin miscompares++; $display("FAIL first_plots: got %0d expected 32", np); end
    vectors++;
    if (dc !== 34) begin miscompares++; $display("FAIL first_done_cycle: got %0d expected 34", dc); end
    vectors++;
    if (nb !== 34) begin miscompares++; $display("FAIL first_busy_cycles: got %0d expected 34", nb); end
    vectors++;
    if (nd !== 1) begin miscompares++; $display("FAIL first_done_count: got %0d expected 1", nd); end
    if (np > 0) begin
      vectors++;
      if (cap_cyc[0] !== 2) begin miscompares++; $display("FAIL first_plot_cycle: got %0d expected 2", cap_cyc[0]); end
    end
    for (int k = 0; k < 32 && k < np; k++) begin
      got = {cap_x[k], cap_y[k], cap_c[k]};
      exp = {8'(k % 8), 7'(112 + k / 8), 3'b111};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL first_pixel_%0d: got %h expected %h", k, got, exp);
      end
    end
  endtask

  task automatic test_unchanged();
    int np, dc, nd, nb;
    run_redraw(8'd0, 0, 0, 8'd0, 0, np, dc, nd, nb);
    vectors++;
    if (np !== 0) begin miscompares++; $display("FAIL same_plots: got %0d expected 0", np); end
    vectors++;
    if (dc !== 2) begin miscompares++; $display("FAIL same_done_cycle: got %0d expected 2", dc); end
    vectors++;
    if (nb !== 2) begin miscompares++; $display("FAIL same_busy_cycles: got %0d expected 2", nb); end
  endtask

  task automatic test_move();
    int np, dc, nd, nb;
    logic [17:0] got, exp;
    run_redraw(8'd5, 0, 0, 8'd0, 0, np, dc, nd, nb);
    vectors++;
    if (np !== 64) begin miscompares++; $display("FAIL move_plots: got %0d expected 64", np); end
    vectors++;
    if (dc !== 66) begin miscompares++; $display("FAIL move_done_cycle: got %0d expected 66", dc); end
    if (np == 64) begin
      vectors++;
      if ({cap_cyc[0], cap_cyc[63]} !== {32'd2, 32'd65}) begin
        miscompares++;
        $display("FAIL move_plot_span: got %0d..%0d expected 2..65", cap_cyc[0], cap_cyc[63]);
      end
    end
    for (int k = 0; k < 64 && k < np; k++) begin
      got = {cap_x[k], cap_y[k], cap_c[k]};
      if (k < 32) exp = {8'(k % 8), 7'(112 + k / 8), 3'b000};
      else        exp = {8'(5 + (k - 32) % 8), 7'(112 + (k - 32) / 8), 3'b111};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL move_pixel_%0d: got %h expected %h", k, got, exp);
      end
    end
  endtask

  task automatic test_clip();
    int np, dc, nd, nb;
    logic [17:0] got, exp;
    run_redraw(8'd155, 0, 0, 8'd0, 0, np, dc, nd, nb);
    vectors++;
    if (np !== 52) begin miscompares++; $display("FAIL clip_plots: got %0d expected 52", np); end
    vectors++;
    if (dc !== 66) begin miscompares++; $display("FAIL clip_done_cycle: got %0d expected 66", dc); end
    vectors++;
    if ({cyc_plot[39], cyc_x[39]} !== {1'b0, 8'd159}) begin
      miscompares++;
      $display("FAIL clip_hold_cycle39: got plot=%0d x=%0d expected plot=0 x=159", cyc_plot[39], cyc_x[39]);
    end
    vectors++;
    if ({cyc_plot[42], cyc_x[42]} !== {1'b1, 8'd155}) begin
      miscompares++;
      $display("FAIL clip_row1_cycle42: got plot=%0d x=%0d expected plot=1 x=155", cyc_plot[42], cyc_x[42]);
    end
    for (int k = 0; k < 20 && (32 + k) < np; k++) begin
      got = {cap_x[32 + k], cap_y[32 + k], cap_c[32 + k]};
      exp = {8'(155 + k % 5), 7'(112 + k / 5), 3'b111};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL clip_pixel_%0d: got %h expected %h", k, got, exp);
      end
    end
  endtask

  task automatic test_ignored_tick();
    int np, dc, nd, nb;
    logic [7:0] ex;
    run_redraw(8'd20, 10, 20, 8'd40, 5, np, dc, nd, nb);
    vectors++;
    if (np !== 52) begin miscompares++; $display("FAIL ign_plots: got %0d expected 52", np); end
    vectors++;
    if (dc !== 66) begin miscompares++; $display("FAIL ign_done_cycle: got %0d expected 66", dc); end
    vectors++;
    if (nd !== 1) begin miscompares++; $display("FAIL ign_done_count: got %0d expected 1", nd); end
    vectors++;
    if (nb !== 66) begin miscompares++; $display("FAIL ign_busy_cycles: got %0d expected 66", nb); end
    for (int k = 0; k < 32 && (20 + k) < np; k++) begin
      ex = 8'(20 + k % 8);
      vectors++;
      if (cap_x[20 + k] !== ex) begin
        miscompares++;
        $display("FAIL ign_draw_x_%0d: got %0d expected %0d", k, cap_x[20 + k], ex);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_bd [1:6];
    exp_bd[1] = 2'b10; exp_bd[2] = 2'b11; exp_bd[3] = 2'b00;
    exp_bd[4] = 2'b10; exp_bd[5] = 2'b11; exp_bd[6] = 2'b00;
    x_val      = 8'd20;
    frame_tick = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      vectors++;
      if ({busy, done} !== exp_bd[c]) begin
        miscompares++;
        $display("FAIL held_tick_cycle%0d: got busy,done=%b expected %b", c, {busy, done}, exp_bd[c]);
      end
      if (c == 5) frame_tick = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    int np, dc, nd, nb;
    x_val      = 8'd60;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    for (int c = 2; c <= 51; c++) step();
    vectors++;
    if ({vga_plot, vga_x, vga_y, vga_colour, busy} !== {1'b1, 8'd61, 7'd114, 3'b111, 1'b1}) begin
      miscompares++;
      $display("FAIL mid_pixel17: got plot=%0d x=%0d y=%0d c=%0d busy=%0d expected 1 61 114 7 1",
               vga_plot, vga_x, vga_y, vga_colour, busy);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    vectors++;
    if ({vga_plot, busy, done, vga_x, vga_colour} !== 13'd0) begin
      miscompares++;
      $display("FAIL mid_reset_idle: got plot=%0d busy=%0d done=%0d x=%0d c=%0d expected all 0",
               vga_plot, busy, done, vga_x, vga_colour);
    end
    step();
    vectors++;
    if ({vga_plot, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL mid_reset_stays_idle: got %b expected 00", {vga_plot, busy});
    end
    run_redraw(8'd30, 0, 0, 8'd0, 0, np, dc, nd, nb);
    vectors++;
    if (np !== 32) begin miscompares++; $display("FAIL after_reset_plots: got %0d expected 32", np); end
    vectors++;
    if (dc !== 34) begin miscompares++; $display("FAIL after_reset_done_cycle: got %0d expected 34", dc); end
    if (np == 32) begin
      vectors++;
      if ({cap_x[0], cap_y[0], cap_c[0], cap_x[31], cap_y[31]} !==
          {8'd30, 7'd112, 3'b111, 8'd37, 7'd115}) begin
        miscompares++;
        $display("FAIL after_reset_corners: got %0d,%0d c%0d .. %0d,%0d expected 30,112 c7 .. 37,115",
                 cap_x[0], cap_y[0], cap_c[0], cap_x[31], cap_y[31]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_draw();
    test_unchanged();
    test_move();
    test_clip();
    test_ignored_tick();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
